uart_rx: RTL
============

# uart_rx

Serial receive stage of the UART core: synchronises the asynchronous `rx_i` line, detects start bits, samples 8N1 frames at mid-bit using a cycle-count baud divider, and delivers each received byte through a one-entry valid/ready holding register to the receive FIFO. It sits directly between the `rx_i` pin and the core's output FIFO, whose fill level is what `mmio_uart` exposes as `rx_flag` / `rx_data`. Framing errors and overruns are reported as single-cycle pulses.

## Interface
- `D_WIDTH`, 32: width of `baud_div_i`.
- `clk_i`  in  1  system clock.
- `rst_n_i`  in  1  asynchronous, active-low reset. Asserts immediately; deasserts synchronously to `clk_i` via the usual external reset synchroniser.
- `baud_div_i`  in  D_WIDTH  clock cycles per bit. Values 0–3 are treated as 4.
- `rx_i`  in  1  serial input, asynchronous, idle high.
- `out_data_o`  out  8  received byte. Reset 0x00.
- `out_valid_o`  out  1  byte available. Reset 0.
- `out_ready_i`  in  1  consumer accepts the byte when `out_valid_o & out_ready_i`.
- `frame_err_o`  out  1  one-cycle pulse: stop bit sampled low. Reset 0.
- `overrun_o`  out  1  one-cycle pulse: a byte was dropped because the holding register was full. Reset 0.

## Operation
- Synchroniser: two flops, both reset to 1; `rx_s` is the second flop output.
- Divider: `div` is latched from `baud_div_i` (after clamping) on entry to START and held for the whole frame, so changes to `baud_div_i` mid-frame have no effect. `half = div >> 1`.
- Bit counter `cnt` is D_WIDTH wide and is cleared on every state entry and after every sample.
- States:
  - IDLE: if `rx_s == 0`, go to START.
  - START: when `cnt == half-1`, sample `rx_s`.
    - If 0, go to DATA with `bit_idx = 0`.
    - If 1 (false start / glitch), go to IDLE.
  - DATA: when `cnt == div-1`, sample `rx_s` into the shift register, LSB first, then increment `bit_idx`. After the sample with `bit_idx == 7`, go to STOP.
  - STOP: when `cnt == div-1`, sample `rx_s`.
    - If 1: deliver the byte and go to IDLE.
    - If 0: pulse `frame_err_o`, discard the byte, go to BREAK.
  - BREAK: stay until `rx_s == 1`, then go to IDLE. This prevents a held-low line from being read as repeated 0x00 frames.
- Delivery into the holding register:
  - If `out_valid_o == 0`, or `out_ready_i == 1` in the same cycle: load `out_data_o`, set `out_valid_o = 1`.
  - Otherwise: keep the old byte, drop the new byte, pulse `overrun_o`.
- Handshake:
  - `out_valid_o` clears on `out_valid_o & out_ready_i`, unless a delivery occurs in the same cycle (in that case it stays 1 with the new data).
  - `out_data_o` is stable while `out_valid_o` is 1 and not accepted.
- Reset mid-frame: all state returns to reset values (state IDLE, holding register empty). A partial frame is lost with no error pulse. After reset, reception resumes on the next falling edge seen by `rx_s`.

## Timing
- `rx_i` → `rx_s`: 2 cycles.
- IDLE sees `rx_s == 0` in cycle t → START entered at t+1. Start sample at t+1+half-1.
- Data sample k (k = 0..7) occurs `div·(k+1)` cycles after the start sample. Stop sample occurs `9·div` cycles after the start sample.
- Output latency:
  - `out_valid_o` (or `frame_err_o`) is registered and asserts the cycle after the stop sample.
  - `overrun_o` asserts on the same cycle `out_valid_o` would have been loaded.
- Back-to-back frames: IDLE is re-entered the cycle after the stop sample. A new start bit beginning anywhere in the second half of the stop bit is caught.
- Throughput: one byte per `10·div` cycles minimum. The holding register alone absorbs one byte of consumer stall per frame.

## Test plan
- `div = 16`, send 0xA5 in 8N1, `out_ready_i = 1` → `out_valid_o` high for exactly 1 cycle with `out_data_o = 0xA5`; `frame_err_o` and `overrun_o` stay 0.
- `div = 16`, drive `rx_i` low for 4 cycles, then high → no `out_valid_o`, returns to IDLE, no error pulses. A following frame 0x3C is received correctly.
- `div = 16`, frame 0x55 with the stop bit driven low, then line held low for 50 cycles, then high → `frame_err_o` pulses exactly once, no `out_valid_o`, no 0x00 frames received; the next frame 0x0F is received.
- `div = 8`, `out_ready_i = 0`, send 0x11 then 0x22 → `out_data_o = 0x11` held with valid high, one `overrun_o` pulse at the second delivery. Raising ready then accepts 0x11 and `out_valid_o` falls.
- `div = 4` (also `baud_div_i = 0`, which must behave identically), send 0x00, 0xFF, 0x81 back-to-back, `out_ready_i = 1` → three valid pulses in order with correct data; `baud_div_i` changed to 100 mid-frame does not corrupt the current byte.
- Assert `rst_n_i` during DATA of a frame → all outputs 0 immediately. After release, the remainder of the frame produces no `out_valid_o` unless a genuine start bit is seen; the next full frame 0xC3 is received.

Source files
------------

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   Serial receive stage of the UART core. Synchronises the asynchronous rx_i
//   line, detects start bits, samples 8N1 frames at mid-bit using a
//   cycle-count baud divider, and hands each byte to the receive FIFO through
//   a one-entry valid/ready holding register.
//
// Parameters
//   D_WIDTH      width of baud_div_i (default 32)
//
// Ports
//   clk_i        in   system clock
//   rst_n_i      in   asynchronous active-low reset
//   baud_div_i   in   clock cycles per bit; 0..3 are treated as 4
//   rx_i         in   serial input, asynchronous, idle high
//   out_data_o   out  received byte (holding register)
//   out_valid_o  out  holding register contains a byte
//   out_ready_i  in   consumer accepts when out_valid_o & out_ready_i
//   frame_err_o  out  one-cycle pulse: stop bit sampled low
//   overrun_o    out  one-cycle pulse: byte dropped, holding register full
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int unsigned D_WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [D_WIDTH-1:0] baud_div_i,
  input  logic               rx_i,
  output logic [7:0]         out_data_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               frame_err_o,
  output logic               overrun_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  localparam logic [D_WIDTH-1:0] MIN_DIV = D_WIDTH'(4);
  localparam logic [D_WIDTH-1:0] ONE     = D_WIDTH'(1);

  // Input synchroniser; both stages reset to the idle (high) line level.
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  // Frame state
  state_t             state_q, state_d;
  logic [D_WIDTH-1:0] div_q, div_d;
  logic [D_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;

  logic [D_WIDTH-1:0] div_clamp;
  logic [D_WIDTH-1:0] half_m1;
  logic [D_WIDTH-1:0] div_m1;
  logic               deliver;
  logic               frame_err_d;

  assign div_clamp = (baud_div_i < MIN_DIV) ? MIN_DIV : baud_div_i;
  assign half_m1   = (div_q >> 1) - ONE;
  assign div_m1    = div_q - ONE;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      div_q     <= MIN_DIV;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = cnt_q + ONE;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    deliver     = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = S_START;
          // Divider is frozen for the whole frame from here on.
          div_d   = div_clamp;
        end
      end

      S_START: begin
        if (cnt_q == half_m1) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end else begin
            // Line went back high before mid start bit: glitch, not a frame.
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (cnt_q == div_m1) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end

      S_STOP: begin
        if (cnt_q == div_m1) begin
          cnt_d = '0;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        // Wait out a held-low line so it is not decoded as 0x00 frames.
        cnt_d = '0;
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Holding register and status pulses
  logic [7:0] out_data_d;
  logic       out_valid_d;
  logic       overrun_d;

  always_comb begin
    out_data_d  = out_data_o;
    out_valid_d = out_valid_o;
    overrun_d   = 1'b0;

    if (deliver) begin
      // A byte accepted in this same cycle frees the slot for the new one.
      if (!out_valid_o || out_ready_i) begin
        out_data_d  = shift_q;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_o && out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_data_o  <= '0;
      out_valid_o <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      out_data_o  <= out_data_d;
      out_valid_o <= out_valid_d;
      frame_err_o <= frame_err_d;
      overrun_o   <= overrun_d;
    end
  end

endmodule
